// File: rtl/usr_seq_pkg.sv
// Shared encodings and types for the universal-shift-register sequencer.
package usr_seq_pkg;

  localparam int USR_WIDTH = 4;
  localparam int USR_CNT_W = 3;

  // Op codes are chosen so that a shift op is also its own register select value.
  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef struct packed {
    op_e                  op;
    logic [USR_CNT_W-1:0] cnt;
    logic [USR_WIDTH-1:0] data;
  } cmd_t;

endpackage

// File: rtl/usr_seq_cmdq.sv
// Two-entry command FIFO placed in front of the sequencer FSM.
module usr_seq_cmdq #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data
);

  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               push_fire, pop_fire;

  // A push on a full FIFO is refused even if a pop happens in the same cycle.
  assign push_ready = (cnt_q != 2'd2);
  assign pop_valid  = (cnt_q != 2'd0);
  assign pop_data   = mem_q[rd_ptr_q];
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop & pop_valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_fire) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push_fire} - {1'b0, pop_fire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving a universal shift register (hold/right/left/load).
// Define USR_SEQ_CMDQ_EN to place a 2-entry command FIFO in front of the FSM.
module usr_seq_ctrl
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH,
  parameter int CNT_W = USR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_d_in,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    op_e              op;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data;
  } cmd_w_t;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  cmd_w_t in_cmd, head;
  logic   head_valid, start;

  assign in_cmd = '{op: op_e'(cmd_op), cnt: cmd_cnt, data: cmd_data};
  assign start  = head_valid && (state_q == ST_IDLE);

`ifdef USR_SEQ_CMDQ_EN
  logic q_ready;

  usr_seq_cmdq #(.DW($bits(cmd_w_t))) u_cmdq (
    .clk        (clk),
    .rst        (rst),
    .push_valid (cmd_valid),
    .push_ready (q_ready),
    .push_data  (in_cmd),
    .pop        (start),
    .pop_valid  (head_valid),
    .pop_data   (head)
  );

  assign cmd_ready = q_ready & ~rst;
`else
  assign head       = in_cmd;
  assign head_valid = cmd_valid;
  assign cmd_ready  = (state_q == ST_IDLE) & ~rst;
`endif

  // LOAD reuses the shift down-counter with a count of one.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sel_d   = SEL_HOLD;
    din_d   = din_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = head.op;
          if (head.op == OP_LOAD) begin
            state_d = ST_EXEC;
            cnt_d   = CNT_W'(1);
            sel_d   = SEL_LOAD;
            din_d   = head.data;
          end else if (head.op == OP_NOP || head.cnt == '0) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_EXEC;
            cnt_d   = head.cnt;
            sel_d   = head.op;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          sel_d = op_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      sel_q   <= SEL_HOLD;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign usr_select = sel_q;
  assign usr_d_in   = din_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
